// File: rtl/merge_pass_scheduler.sv
// merge_pass_scheduler
// Multi-pass sequencer for the F-way merger tree. One job sorts N records
// that start out as sorted runs of length R0. For each group of F runs it
// issues one read descriptor per channel and one write descriptor, then
// waits for the write path to retire the group. Passes alternate between
// buffer A (src_base) and buffer B (dst_base) until one run of N remains.
//
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   start                          job start pulse (accepted only when idle)
//   num_records, init_run_len      N and R0, latched on start (R0 of 0 acts as 1)
//   src_base, dst_base             byte bases of buffer A and buffer B
//   busy, done                     job in progress / one-cycle completion pulse
//   pass_count, result_in_dst      passes completed / final run lives in B
//   rd_cmd_*                       per-channel run descriptors (valid/ready)
//   wr_cmd_*                       group output descriptor (valid/ready)
//   wr_done                        write path retired the group's last beat
//   perf_busy_cycles, perf_issue_stall  performance counters
//
// Build option: define MERGE_SCHED_PERF_EN to enable the performance
// counters; when it is undefined both counter ports read as zero.
module merge_pass_scheduler #(
    parameter int NUM_READ_CHANNELS  = 16,
    parameter int C_SORTER_BIT_WIDTH = 32,
    parameter int C_ADDR_WIDTH       = 64,
    parameter int C_LEN_WIDTH        = 32
) (
    input  logic                                      aclk,
    input  logic                                      areset_n,
    input  logic                                      start,
    input  logic [C_LEN_WIDTH-1:0]                    num_records,
    input  logic [C_LEN_WIDTH-1:0]                    init_run_len,
    input  logic [C_ADDR_WIDTH-1:0]                   src_base,
    input  logic [C_ADDR_WIDTH-1:0]                   dst_base,
    output logic                                      busy,
    output logic                                      done,
    output logic [7:0]                                pass_count,
    output logic                                      result_in_dst,
    output logic [NUM_READ_CHANNELS-1:0]              rd_cmd_valid,
    input  logic [NUM_READ_CHANNELS-1:0]              rd_cmd_ready,
    output logic [NUM_READ_CHANNELS*C_ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [NUM_READ_CHANNELS*C_LEN_WIDTH-1:0]  rd_cmd_len,
    output logic                                      wr_cmd_valid,
    input  logic                                      wr_cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]                   wr_cmd_addr,
    output logic [C_LEN_WIDTH-1:0]                    wr_cmd_len,
    input  logic                                      wr_done,
    output logic [31:0]                               perf_busy_cycles,
    output logic [31:0]                               perf_issue_stall
);

    localparam int F    = NUM_READ_CHANNELS;
    localparam int LOGF = $clog2(F);
    localparam int RBS  = $clog2(C_SORTER_BIT_WIDTH / 8);
    localparam int RW   = C_LEN_WIDTH + LOGF;      // run length register
    localparam int GW   = C_LEN_WIDTH + LOGF + 1;  // group base / offsets

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ARM, S_ISSUE, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [C_LEN_WIDTH-1:0]  r_n;
    logic [RW-1:0]           r_run;
    logic [GW-1:0]           r_grp;
    logic [GW-1:0]           r_off;
    logic [LOGF-1:0]         r_k;
    logic [C_ADDR_WIDTH-1:0] r_src;
    logic [C_ADDR_WIDTH-1:0] r_dst;
    logic                    r_busy;
    logic                    r_done;
    logic [7:0]              r_pass;
    logic                    r_res_dst;
    logic [F-1:0]            r_rd_valid;
    logic [C_ADDR_WIDTH-1:0] r_rd_addr [F];
    logic [C_LEN_WIDTH-1:0]  r_rd_len  [F];
    logic                    r_wr_valid;
    logic [C_ADDR_WIDTH-1:0] r_wr_addr;
    logic [C_LEN_WIDTH-1:0]  r_wr_len;

    logic [C_LEN_WIDTH-1:0]  w_r0_eff;
    logic                    w_trivial;
    logic [GW-1:0]           w_n_ext;
    logic [GW-1:0]           w_run_ext;
    logic [GW-1:0]           w_fr;
    logic [GW-1:0]           w_rem;
    logic [C_LEN_WIDTH-1:0]  w_len_k;
    logic [C_ADDR_WIDTH-1:0] w_addr_k;
    logic [GW-1:0]           w_wr_rem;
    logic [GW-1:0]           w_grp_nxt;
    logic                    w_pass_end;
    logic [RW+LOGF-1:0]      w_run_mul;
    logic [RW-1:0]           w_run_sat;
    logic                    w_last_pass;
    logic [F-1:0]            w_rd_pend;
    logic                    w_wr_pend;
    logic                    w_all_acc;

    assign w_r0_eff  = (init_run_len == {C_LEN_WIDTH{1'b0}})
                       ? {{(C_LEN_WIDTH-1){1'b0}}, 1'b1} : init_run_len;
    assign w_trivial = (num_records == {C_LEN_WIDTH{1'b0}}) || (w_r0_eff >= num_records);

    assign w_n_ext   = {{(GW-C_LEN_WIDTH){1'b0}}, r_n};
    assign w_run_ext = {1'b0, r_run};
    // F*R by shift; R < N whenever this is used, so it fits in GW bits.
    assign w_fr      = w_run_ext << LOGF;

    // Channel k descriptor from the running offset G + k*R.
    assign w_rem     = w_n_ext - r_off;
    assign w_len_k   = (r_off >= w_n_ext) ? {C_LEN_WIDTH{1'b0}}
                       : C_LEN_WIDTH'((w_run_ext < w_rem) ? w_run_ext : w_rem);
    assign w_addr_k  = r_src + (C_ADDR_WIDTH'(r_off) << RBS);

    assign w_wr_rem  = w_n_ext - r_grp;
    assign w_grp_nxt = r_grp + w_fr;
    assign w_pass_end = (w_grp_nxt >= w_n_ext);

    // Next-pass run length, saturating instead of wrapping.
    assign w_run_mul   = {r_run, {LOGF{1'b0}}};
    assign w_run_sat   = (|w_run_mul[RW+LOGF-1:RW]) ? {RW{1'b1}} : w_run_mul[RW-1:0];
    assign w_last_pass = (w_run_sat >= {{LOGF{1'b0}}, r_n});

    assign w_rd_pend = r_rd_valid & ~rd_cmd_ready;
    assign w_wr_pend = r_wr_valid & ~wr_cmd_ready;
    assign w_all_acc = (w_rd_pend == {F{1'b0}}) && !w_wr_pend;

    // State register.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_trivial ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_k == {LOGF{1'b1}}) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_ARM:   w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_all_acc) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_NEXT: begin
                if (w_pass_end && w_last_pass) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job registers, descriptor generation and handshakes.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_n        <= '0;
            r_run      <= '0;
            r_grp      <= '0;
            r_off      <= '0;
            r_k        <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 8'd0;
            r_res_dst  <= 1'b0;
            r_rd_valid <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_len   <= '0;
            for (int i = 0; i < F; i++) begin
                r_rd_addr[i] <= '0;
                r_rd_len[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n       <= num_records;
                        r_run     <= {{LOGF{1'b0}}, w_r0_eff};
                        r_grp     <= '0;
                        r_off     <= '0;
                        r_k       <= '0;
                        r_src     <= src_base;
                        r_dst     <= dst_base;
                        r_pass    <= 8'd0;
                        r_res_dst <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_rd_addr[r_k] <= w_addr_k;
                    r_rd_len[r_k]  <= w_len_k;
                    r_off          <= r_off + w_run_ext;
                    r_k            <= r_k + {{(LOGF-1){1'b0}}, 1'b1};
                    r_wr_addr      <= r_dst + (C_ADDR_WIDTH'(r_grp) << RBS);
                    r_wr_len       <= C_LEN_WIDTH'((w_fr < w_wr_rem) ? w_fr : w_wr_rem);
                end
                S_ARM: begin
                    r_rd_valid <= {F{1'b1}};
                    r_wr_valid <= 1'b1;
                end
                S_ISSUE: begin
                    r_rd_valid <= w_rd_pend;
                    r_wr_valid <= w_wr_pend;
                end
                S_NEXT: begin
                    r_k <= '0;
                    if (w_pass_end) begin
                        r_pass <= r_pass + 8'd1;
                        r_src  <= r_dst;
                        r_dst  <= r_src;
                        r_run  <= w_run_sat;
                        r_grp  <= '0;
                        r_off  <= '0;
                    end else begin
                        r_grp  <= w_grp_nxt;
                        r_off  <= w_grp_nxt;
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_res_dst <= r_pass[0];
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass_count    = r_pass;
    assign result_in_dst = r_res_dst;
    assign rd_cmd_valid  = r_rd_valid;
    assign wr_cmd_valid  = r_wr_valid;
    assign wr_cmd_addr   = r_wr_addr;
    assign wr_cmd_len    = r_wr_len;

    for (genvar g = 0; g < F; g++) begin : g_pack
        assign rd_cmd_addr[g*C_ADDR_WIDTH +: C_ADDR_WIDTH] = r_rd_addr[g];
        assign rd_cmd_len[g*C_LEN_WIDTH +: C_LEN_WIDTH]    = r_rd_len[g];
    end

`ifdef MERGE_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    // Saturating busy/stall counters, cleared when a job is accepted.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_perf_busy  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (r_busy && (r_perf_busy != 32'hFFFF_FFFF)) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if ((r_state == S_ISSUE) && !w_all_acc && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_issue_stall = r_perf_stall;
`else
    assign perf_busy_cycles = 32'd0;
    assign perf_issue_stall = 32'd0;
`endif

endmodule

// File: tb/tb_merge_pass_scheduler.sv
// Self-checking bench for merge_pass_scheduler (default parameters).
// A job-level reference model expands (N, R0, A, B) into the expected
// sequence of group descriptors; the DUT's issued descriptors, timing and
// completion status are compared against it.
module tb_merge_pass_scheduler;

    localparam int F  = 16;
    localparam int AW = 64;
    localparam int LW = 32;
    localparam int RB = 4;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   num_records = '0;
    logic [LW-1:0]   init_run_len = '0;
    logic [AW-1:0]   src_base = '0;
    logic [AW-1:0]   dst_base = '0;
    logic            busy, done, result_in_dst;
    logic [7:0]      pass_count;
    logic [F-1:0]    rd_cmd_valid;
    logic [F-1:0]    rd_cmd_ready = '1;
    logic [F*AW-1:0] rd_cmd_addr;
    logic [F*LW-1:0] rd_cmd_len;
    logic            wr_cmd_valid;
    logic            wr_cmd_ready = 1'b1;
    logic [AW-1:0]   wr_cmd_addr;
    logic [LW-1:0]   wr_cmd_len;
    logic            wr_done = 1'b0;
    logic [31:0]     perf_busy_cycles, perf_issue_stall;

    int n_cmp = 0;
    int n_mis = 0;

    longint q_addr[$];
    longint q_len[$];
    longint q_waddr[$];
    longint q_wlen[$];

    merge_pass_scheduler dut (
        .aclk(aclk), .areset_n(areset_n), .start(start),
        .num_records(num_records), .init_run_len(init_run_len),
        .src_base(src_base), .dst_base(dst_base),
        .busy(busy), .done(done), .pass_count(pass_count), .result_in_dst(result_in_dst),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .wr_done(wr_done),
        .perf_busy_cycles(perf_busy_cycles), .perf_issue_stall(perf_issue_stall)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expand a job into its group descriptors from the pass/group rules.
    task automatic build_model(input longint n, input longint r0, input longint a,
                               input longint b, output int passes);
        longint r, g, off, src, dst, t;
        q_addr.delete(); q_len.delete(); q_waddr.delete(); q_wlen.delete();
        r = (r0 == 0) ? 64'd1 : r0;
        passes = 0;
        src = a;
        dst = b;
        if (n == 0 || r >= n) return;
        while (r < n) begin
            for (g = 0; g < n; g += F * r) begin
                for (int k = 0; k < F; k++) begin
                    off = g + k * r;
                    q_addr.push_back(src + off * RB);
                    q_len.push_back((off >= n) ? 64'd0 : (((n - off) < r) ? (n - off) : r));
                end
                q_waddr.push_back(dst + g * RB);
                q_wlen.push_back(((n - g) < F * r) ? (n - g) : F * r);
            end
            passes++;
            t = src; src = dst; dst = t;
            r = r * F;
        end
    endtask

    // mode 0: ready tied high; 1: random ready; 2: channel 5 held off 10 cycles.
    task automatic run_job(input longint n, input longint r0, input longint a,
                           input longint b, input int mode, input bit poke_start);
        int exp_pass, ngrp, c, ic, total, stall_exp;
        logic [F-1:0] acc, rdy;
        logic wacc, wr;
        logic [63:0] pexp;
        build_model(n, r0, a, b, exp_pass);
        ngrp = q_wlen.size();
        @(negedge aclk);
        num_records  = n[LW-1:0];
        init_run_len = r0[LW-1:0];
        src_base     = a;
        dst_base     = b;
        start        = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        total = 0;
        stall_exp = 0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("done_after_start", {63'd0, done}, 64'd0);
        if (ngrp == 0) begin
            @(negedge aclk);
            total++;
            chk("triv_done", {63'd0, done}, 64'd1);
            chk("triv_busy", {63'd0, busy}, 64'd0);
            chk("triv_pass", {56'd0, pass_count}, 64'd0);
            chk("triv_res", {63'd0, result_in_dst}, 64'd0);
            chk("triv_rdv", {48'd0, rd_cmd_valid}, 64'd0);
            chk("triv_wrv", {63'd0, wr_cmd_valid}, 64'd0);
        end else begin
            for (int g = 0; g < ngrp; g++) begin
                c = 0;
                while (rd_cmd_valid == '0 && c < 200) begin
                    @(negedge aclk);
                    c++; total++;
                end
                chk("issue_latency", 64'(c), (g == 0) ? 64'(F + 1) : 64'(F + 2));
                acc = '0; wacc = 1'b0; ic = 0;
                while (!((&acc) && wacc) && ic < 500) begin
                    chk("rd_valid_mask", {48'd0, rd_cmd_valid}, {48'd0, ~acc});
                    chk("wr_valid", {63'd0, wr_cmd_valid}, {63'd0, ~wacc});
                    for (int k = 0; k < F; k++) begin
                        if (!acc[k]) begin
                            chk($sformatf("rd_addr g%0d k%0d", g, k), rd_cmd_addr[k*AW +: AW], q_addr[g*F+k]);
                            chk($sformatf("rd_len g%0d k%0d", g, k), {32'd0, rd_cmd_len[k*LW +: LW]}, q_len[g*F+k]);
                        end
                    end
                    if (!wacc) begin
                        chk($sformatf("wr_addr g%0d", g), wr_cmd_addr, q_waddr[g]);
                        chk($sformatf("wr_len g%0d", g), {32'd0, wr_cmd_len}, q_wlen[g]);
                    end
                    if (mode == 1) begin
                        rdy = F'($urandom);
                        wr  = 1'($urandom_range(0, 1));
                    end else if (mode == 2) begin
                        rdy = (ic < 10) ? 16'hFFDF : 16'hFFFF;
                        wr  = 1'b1;
                    end else begin
                        rdy = '1;
                        wr  = 1'b1;
                    end
                    if (((~acc & ~rdy) != '0) || (!wacc && !wr)) stall_exp++;
                    rd_cmd_ready = rdy;
                    wr_cmd_ready = wr;
                    acc  = acc | rdy;
                    wacc = wacc | wr;
                    @(negedge aclk);
                    ic++; total++;
                end
                chk("issue_bounded", 64'((&acc) && wacc), 64'd1);
                chk("rd_valid_clear", {48'd0, rd_cmd_valid}, 64'd0);
                chk("wr_valid_clear", {63'd0, wr_cmd_valid}, 64'd0);
                if (poke_start && g == 0) begin
                    num_records = 32'd7; init_run_len = 32'd1; start = 1'b1;
                    @(negedge aclk);
                    start = 1'b0; total++;
                end
                wr_done = 1'b1;
                @(negedge aclk);
                wr_done = 1'b0; total++;
            end
            c = 0;
            while (!done && c < 50) begin
                @(negedge aclk);
                c++; total++;
            end
            chk("done_latency", 64'(c), 64'd2);
            chk("done_busy", {63'd0, busy}, 64'd0);
            chk("pass_count", {56'd0, pass_count}, 64'(exp_pass));
            chk("result_in_dst", {63'd0, result_in_dst}, 64'(exp_pass % 2));
        end
`ifdef MERGE_SCHED_PERF_EN
        pexp = 64'(total);
`else
        pexp = 64'd0;
`endif
        chk("perf_busy", {32'd0, perf_busy_cycles}, pexp);
`ifdef MERGE_SCHED_PERF_EN
        pexp = 64'(stall_exp);
`else
        pexp = 64'd0;
`endif
        chk("perf_stall", {32'd0, perf_issue_stall}, pexp);
        @(negedge aclk);
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    // Abandon a job via reset, either mid-issue (valids pending) or in WAIT.
    task automatic reset_midjob(input bit in_issue);
        int c;
        bit seen;
        rd_cmd_ready = in_issue ? '0 : '1;
        wr_cmd_ready = !in_issue;
        @(negedge aclk);
        num_records = 32'd100; init_run_len = 32'd4;
        src_base = 64'h1000; dst_base = 64'h8000; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        c = 0;
        while (rd_cmd_valid == '0 && c < 100) begin
            @(negedge aclk);
            c++;
        end
        @(negedge aclk);
        if (in_issue) begin
            chk("rst_pre_valid", {48'd0, rd_cmd_valid}, 64'hFFFF);
        end else begin
            chk("rst_pre_valid", {48'd0, rd_cmd_valid}, 64'd0);
        end
        chk("rst_pre_busy", {63'd0, busy}, 64'd1);
        #2 areset_n = 1'b0;
        #1;
        chk("rst_rdv", {48'd0, rd_cmd_valid}, 64'd0);
        chk("rst_wrv", {63'd0, wr_cmd_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_pass", {56'd0, pass_count}, 64'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        rd_cmd_ready = '1;
        wr_cmd_ready = 1'b1;
        wr_done = 1'b1;
        @(negedge aclk);
        wr_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_cmd_valid != '0 || wr_cmd_valid || busy || done) seen = 1'b1;
            @(negedge aclk);
        end
        chk("no_reissue", {63'd0, seen}, 64'd0);
    endtask

    initial begin
        longint rn, rr, ra, rb;
        repeat (3) @(negedge aclk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_rdv", {48'd0, rd_cmd_valid}, 64'd0);
        chk("reset_wrv", {63'd0, wr_cmd_valid}, 64'd0);
        chk("reset_addr0", rd_cmd_addr[AW-1:0], 64'd0);
        chk("reset_len0", {32'd0, rd_cmd_len[LW-1:0]}, 64'd0);
        chk("reset_pass", {56'd0, pass_count}, 64'd0);
        chk("reset_perf", {perf_busy_cycles, perf_issue_stall}, 64'd0);
        areset_n = 1'b1;
        @(negedge aclk);

        run_job(64, 4, 64'h1000_0000, 64'h2000_0000, 0, 1'b0);
        run_job(100, 4, 64'h4000, 64'h9000, 0, 1'b1);
        run_job(64, 4, 64'h100, 64'h20000, 2, 1'b0);
        run_job(0, 5, 64'h100, 64'h200, 0, 1'b0);
        run_job(8, 8, 64'h100, 64'h200, 0, 1'b0);
        run_job(5, 0, 64'h300, 64'h700, 1, 1'b0);
        run_job(1, 0, 64'h300, 64'h700, 0, 1'b0);

        reset_midjob(1'b1);
        run_job(100, 4, 64'h4000, 64'h9000, 1, 1'b0);
        reset_midjob(1'b0);
        run_job(300, 1, 64'hFFFF_FFFF_FFFF_F000, 64'h5000, 1, 1'b0);

        for (int j = 0; j < 4; j++) begin
            rn = longint'($urandom_range(1, 1500));
            rr = longint'($urandom_range(0, 40));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            run_job(rn, rr, ra, rb, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
